// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and load-stall state encoding for the hazard controller
package hazard_pkg;
  localparam int REG_ZERO = 0;
  localparam int DEF_LOAD_LATENCY = 1;
  localparam int DEF_FLUSH_DEPTH = 1;
  localparam int DEF_MULDIV_CYCLES = 32;
  typedef enum logic {IDLE = 1'b0, LOAD_STALL = 1'b1} load_state_e;
endpackage

// File: rtl/hazard_down_counter.sv
// hazard_down_counter: loadable down counter that saturates at zero and flags non-zero
module hazard_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         nz
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (nz) cnt <= cnt - W'(1);
  assign nz = |cnt;
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use, branch-flush and HI/LO interlock control for the 5-stage pipeline
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_BranchControl,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  IF_ID_ReadsHiLo,
  input  logic                  muldiv_start,
  output logic                  Stall,
  output logic                  Flush,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Bubble,
  output logic                  MulDivBusy
);
  load_state_e state;
  logic load_nz, flush_nz, md_nz;
  logic load_hit, hilo_hit, flush_raw, load_start;
  // The load counter is the FSM state register: LOAD_STALL exactly while it is non-zero
  always_comb begin
    state = load_nz ? LOAD_STALL : IDLE;
    load_hit = ID_EX_MemRead && ID_EX_RegisterRt != REG_ADDR_W'(REG_ZERO) &&
               (ID_EX_RegisterRt == IF_ID_RegisterRs || ID_EX_RegisterRt == IF_ID_RegisterRt);
    hilo_hit = IF_ID_ReadsHiLo && md_nz;
    flush_raw = in_BranchControl || flush_nz;
    load_start = state == IDLE && load_hit && !flush_raw;
    Flush = !reset && flush_raw;
    Stall = !reset && !flush_raw && (load_hit || state == LOAD_STALL || hilo_hit);
    PCWrite = !Stall;
    IF_ID_Write = !Stall;
    ID_EX_Bubble = Stall;
    MulDivBusy = !reset && md_nz;
  end
  hazard_down_counter #(.W(3)) u_load (
    .clk(clk), .reset(reset), .clear(flush_raw), .load(load_start),
    .load_val(3'(LOAD_LATENCY - 1)), .nz(load_nz)
  );
  hazard_down_counter #(.W(3)) u_flush (
    .clk(clk), .reset(reset), .clear(1'b0), .load(in_BranchControl),
    .load_val(3'(FLUSH_DEPTH - 1)), .nz(flush_nz)
  );
  hazard_down_counter #(.W(6)) u_md (
    .clk(clk), .reset(reset), .clear(1'b0), .load(muldiv_start),
    .load_val(6'(MULDIV_CYCLES - 1)), .nz(md_nz)
  );
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core; next generation of the load-use/branch hazard detector.
- Sits between the IF/ID and ID/EX pipeline registers and drives PC, IF/ID write enables, ID/EX bubble and the flush line.
- Adds three things the previous generation lacks: multi-cycle load-use stalls (configurable load latency), multi-cycle branch flush, and a HI/LO busy interlock for the iterative mult/div unit.
- Register $0 is excluded from dependency checks.

Parameters:
REG_ADDR_W, 5, register-index width
LOAD_LATENCY, 1, stall cycles per load-use hazard (1..7)
FLUSH_DEPTH, 1, cycles Flush stays high per taken branch (1..7)
MULDIV_CYCLES, 32, cycles the mult/div unit is busy after a start (2..63)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_BranchControl  in  1  branch resolved taken this cycle
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_RegisterRt  in  REG_ADDR_W  load destination
IF_ID_RegisterRs  in  REG_ADDR_W  ID source rs
IF_ID_RegisterRt  in  REG_ADDR_W  ID source rt
IF_ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mult/div
muldiv_start  in  1  mult/div issued into EX this cycle
Stall  out  1  hold PC and IF/ID
Flush  out  1  squash IF/ID
PCWrite  out  1  = ~Stall
IF_ID_Write  out  1  = ~Stall
ID_EX_Bubble  out  1  = Stall (insert NOP into ID/EX)
MulDivBusy  out  1  mult/div counter non-zero

Behaviour:
- Reset: all counters cleared. While reset=1, outputs are forced to Stall=0, Flush=0, PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, MulDivBusy=0.
- Registered state:
  - load_cnt: 3 bits.
  - flush_cnt: 3 bits.
  - md_cnt: 6 bits.
  - Load stall FSM: IDLE / LOAD_STALL, where LOAD_STALL ⇔ load_cnt≠0.
- load_hit (combinational):
  - Condition: ID_EX_MemRead && ID_EX_RegisterRt≠0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || ID_EX_RegisterRt==IF_ID_RegisterRt).
  - IDLE & load_hit: the FSM enters LOAD_STALL with load_cnt=LOAD_LATENCY-1. If LOAD_LATENCY=1 it stays IDLE.
  - LOAD_STALL: load_cnt decrements each cycle and returns to IDLE at 0. A new load_hit while in LOAD_STALL is ignored, because the bubble removes the load from EX.
- hilo_hit = IF_ID_ReadsHiLo && md_cnt≠0.
- Stall = load_hit | (load_cnt≠0) | hilo_hit, gated to 0 when Flush=1. Stall is combinational: it is asserted in the same cycle the hazard is detected.
- Flush = in_BranchControl | (flush_cnt≠0).
  - in_BranchControl loads flush_cnt=FLUSH_DEPTH-1.
  - flush_cnt otherwise decrements to 0.
  - A branch while flush_cnt≠0 reloads the counter (no accumulation).
- Flush priority: any cycle with Flush=1 forces Stall=0 and clears load_cnt next edge, since the dependent instruction is squashed. md_cnt is unaffected, because the mult/div is older than the branch.
- Mult/div counter:
  - muldiv_start loads md_cnt=MULDIV_CYCLES-1 and sets MulDivBusy next cycle; md_cnt then decrements to 0.
  - muldiv_start while busy restarts the count.
  - MulDivBusy=1 for exactly MULDIV_CYCLES-1 cycles after the start edge.
- Counter decrements saturate at 0, with no wrap.
- Simultaneous load_hit & hilo_hit: single Stall. The longer of the two sources governs release.
- Reset mid-stall or mid-flush: outputs become inactive in the reset cycle, and counters read 0 on the next edge.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_ZERO constant.
  - FSM state encoding IDLE=1'b0, LOAD_STALL=1'b1.
  - Default latency constants.
- One natural sub-module, hazard_down_counter: load / decrement / saturating-zero with a non-zero flag, parametrised width. It is instantiated three times (load, flush, md).

Test Plan:
- Load-use, default params. lw $8 in EX (MemRead=1, Rt=8), ID Rs=8 → Stall=1, PCWrite=0, ID_EX_Bubble=1 for 1 cycle, then Stall=0.
- $0 exclusion. MemRead=1, ID_EX_RegisterRt=0, IF_ID_RegisterRs=0 → Stall=0.
- LOAD_LATENCY=3 with the same hit → Stall high exactly 3 consecutive cycles. Asserting in_BranchControl in cycle 2 → Flush=1, Stall=0 in that cycle, and Stall stays 0 afterwards.
- FLUSH_DEPTH=2: branch pulse → Flush high 2 cycles. A second branch pulse during cycle 2 → Flush high 2 more cycles (3 total).
- MULDIV_CYCLES=4: muldiv_start pulse, then IF_ID_ReadsHiLo=1 held → MulDivBusy and Stall high 3 cycles after the start edge, then 0.
- Reset asserted during LOAD_LATENCY=3 stall cycle 2 → all outputs inactive that cycle; after reset deasserts with no hit, Stall=0.
